// File: rtl/reg_mask_encoder_pkg.sv
// Shared types and default sizing for the register-mask encoder.
package reg_mask_encoder_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefIdxW  = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/reg_mask_encoder_if.sv
// Valid/ready index stream produced by the encoder.
interface reg_mask_encoder_if
  import reg_mask_encoder_pkg::*;
#(
  parameter int unsigned IdxW = DefIdxW
);

  logic            idx_valid;
  logic            idx_ready;
  logic [IdxW-1:0] idx_out;

  modport master (output idx_valid, output idx_out, input idx_ready);
  modport slave  (input idx_valid, input idx_out, output idx_ready);

endinterface

// File: rtl/lsb_encoder.sv
// Combinational lowest-set-bit encoder: index of the least significant set bit plus an any-set flag.
module lsb_encoder #(
  parameter int unsigned Width = 32,
  parameter int unsigned IdxW  = 5
) (
  input  logic [Width-1:0] vec_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/reg_mask_encoder.sv
// Walks a latched multi-hot register mask, emitting one set-bit index per valid/ready transfer,
// lowest index first, and pulses done when the mask is exhausted.
module reg_mask_encoder
  import reg_mask_encoder_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned IdxW  = DefIdxW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [Width-1:0]    mask_in,
  input  logic                abort,
  reg_mask_encoder_if.master  idx_if,
  output logic                busy,
  output logic                done,
  output logic [IdxW:0]       count
);

  state_e           state_q, state_d;
  logic [Width-1:0] mask_q, mask_d;
  logic [IdxW:0]    count_q, count_d;

  logic [IdxW-1:0]  enc_idx;
  logic             enc_any;
  logic             valid;
  logic             xfer;

  lsb_encoder #(
    .Width (Width),
    .IdxW  (IdxW)
  ) u_lsb_encoder (
    .vec_i (mask_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign valid = (state_q == StScan) && enc_any;
  assign xfer  = valid && idx_if.idx_ready && !abort;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d  = mask_in;
          count_d = '0;
          state_d = (|mask_in) ? StScan : StDone;
        end
      end
      StScan: begin
        // Abort wins over any transfer offered in the same cycle.
        if (abort) begin
          mask_d  = '0;
          state_d = StIdle;
        end else if (xfer) begin
          mask_d  = mask_q & ~(Width'(1) << enc_idx);
          count_d = count_q + (IdxW + 1)'(1);
          if (mask_d == '0) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (abort) begin
          mask_d = '0;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign idx_if.idx_valid = valid;
  assign idx_if.idx_out   = valid ? enc_idx : '0;
  assign busy             = (state_q == StScan) || (state_q == StDone);
  assign done             = (state_q == StDone) && !abort;
  assign count            = count_q;

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Directed bench for reg_mask_encoder with an index scoreboard filled from each loaded mask.
module tb_reg_mask_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] mask_in;
  logic        abort;
  logic        busy;
  logic        done;
  logic [5:0]  count;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int dones, valids, cycles;

  reg_mask_encoder_if #(.IdxW(5)) ifc ();

  reg_mask_encoder #(
    .Width (32),
    .IdxW  (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mask_in (mask_in),
    .abort   (abort),
    .idx_if  (ifc),
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads a mask and pushes its set-bit indices, ascending, onto the scoreboard.
  task automatic start_job(input logic [31:0] m);
    for (int i = 0; i < 32; i++) begin
      if (m[i]) exp_q.push_back(i);
    end
    start   = 1'b1;
    mask_in = m;
    tick();
    start   = 1'b0;
    mask_in = ~m;
  endtask

  // Compare the index about to transfer at the next edge, if any.
  task automatic observe();
    if (ifc.idx_valid && ifc.idx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_empty observed=%0d expected=none", ifc.idx_out);
      end else begin
        chk("idx", 64'(ifc.idx_out), 64'(exp_q.pop_front()));
      end
    end else if (!ifc.idx_valid) begin
      chk("idx_zero", 64'(ifc.idx_out), 64'd0);
    end
  endtask

  // Runs until busy drops, bounded by budget cycles.
  task automatic drain(input int budget, output int n_done, output int n_valid, output int n_cyc);
    n_done  = 0;
    n_valid = 0;
    n_cyc   = 0;
    while (busy && n_cyc < budget) begin
      if (ifc.idx_valid) n_valid++;
      if (done) n_done++;
      observe();
      tick();
      n_cyc++;
    end
    chk("drain_timeout_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    mask_in       = '0;
    abort         = 1'b0;
    ifc.idx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 64'(ifc.idx_valid), 64'd0);
    chk("rst_idx", 64'(ifc.idx_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(count), 64'd0);

    // Sparse mask with ready held high: 0, 4, 31 back to back.
    ifc.idx_ready = 1'b1;
    start_job(32'h8000_0011);
    chk("sparse_first_valid", 64'(ifc.idx_valid), 64'd1);
    drain(10, dones, valids, cycles);
    chk("sparse_cycles", 64'(cycles), 64'd4);
    chk("sparse_valids", 64'(valids), 64'd3);
    chk("sparse_dones", 64'(dones), 64'd1);
    chk("sparse_count", 64'(count), 64'd3);
    chk("sparse_sb_left", 64'(exp_q.size()), 64'd0);

    // Backpressure holds index 1 for three cycles.
    ifc.idx_ready = 1'b0;
    start_job(32'h0000_000A);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(ifc.idx_valid), 64'd1);
      chk("bp_hold_idx", 64'(ifc.idx_out), 64'd1);
      chk("bp_hold_count", 64'(count), 64'd0);
      tick();
    end
    ifc.idx_ready = 1'b1;
    drain(10, dones, valids, cycles);
    chk("bp_cycles", 64'(cycles), 64'd3);
    chk("bp_dones", 64'(dones), 64'd1);
    chk("bp_count", 64'(count), 64'd2);
    chk("bp_sb_left", 64'(exp_q.size()), 64'd0);

    // Zero mask goes straight to DONE.
    start_job(32'h0);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_valid", 64'(ifc.idx_valid), 64'd0);
    drain(5, dones, valids, cycles);
    chk("zero_cycles", 64'(cycles), 64'd1);
    chk("zero_valids", 64'(valids), 64'd0);
    chk("zero_count", 64'(count), 64'd0);
    chk("zero_done_after", 64'(done), 64'd0);

    // Full mask with a stray start pulse mid-scan.
    start_job(32'hFFFF_FFFF);
    observe();
    start   = 1'b1;
    mask_in = 32'h0000_0001;
    tick();
    start = 1'b0;
    drain(40, dones, valids, cycles);
    chk("full_cycles", 64'(cycles), 64'd32);
    chk("full_valids", 64'(valids), 64'd31);
    chk("full_dones", 64'(dones), 64'd1);
    chk("full_count", 64'(count), 64'd32);
    chk("full_sb_left", 64'(exp_q.size()), 64'd0);
    tick();
    chk("full_idle_busy", 64'(busy), 64'd0);

    // Abort after two transfers.
    start_job(32'h0000_0707);
    observe();
    tick();
    observe();
    tick();
    ifc.idx_ready = 1'b0;
    abort         = 1'b1;
    chk("abort_pre_valid", 64'(ifc.idx_valid), 64'd1);
    chk("abort_pre_idx", 64'(ifc.idx_out), 64'd2);
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("abort_valid", 64'(ifc.idx_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_count", 64'(count), 64'd2);
    tick();
    chk("abort_no_late_done", 64'(done), 64'd0);
    chk("abort_stay_idle", 64'(busy), 64'd0);

    // Reset mid-scan after one transfer.
    ifc.idx_ready = 1'b1;
    start_job(32'h0000_00F0);
    observe();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_valid", 64'(ifc.idx_valid), 64'd0);
    chk("midrst_idx", 64'(ifc.idx_out), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_mask_encoder.md
REG_MASK_ENCODER -- requirements
Module: reg_mask_encoder

Interface
REQ-001 SHALL have parameter Width, default 32, giving the register-mask width (number of architectural registers).
REQ-002 SHALL have parameter IdxW, default 5, giving the index width; IdxW = clog2(Width).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-006 SHALL have port mask_in  input  Width  multi-hot register mask; bit i selects register i.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current job.
REQ-008 SHALL have port idx_ready  input  1  consumer accepts idx_out this cycle.
REQ-009 SHALL have port idx_valid  output  1  idx_out holds a valid register index.
REQ-010 SHALL have port idx_out  output  IdxW  index of the lowest remaining set mask bit.
REQ-011 SHALL have port busy  output  1  high in SCAN and DONE states.
REQ-012 SHALL have port done  output  1  single-cycle pulse when a job completes normally.
REQ-013 SHALL have port count  output  IdxW+1  number of indices accepted in the current or last job.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-015 IDLE: on start=1, SHALL latch mask_in into remaining-mask register, clear count, go to SCAN if mask_in nonzero, else go to DONE.
REQ-016 SCAN: SHALL drive idx_valid=1 and idx_out = position of lowest set bit of remaining mask, combinationally from the register (first index visible the cycle after start).
REQ-017 SCAN: idx_out and idx_valid SHALL stay stable until idx_ready=1 (valid/ready transfer).
REQ-018 On transfer (idx_valid & idx_ready), SHALL clear that bit in the remaining mask and increment count by 1.
REQ-019 If the transfer clears the last set bit, SHALL go to DONE next cycle; else stay in SCAN; at most one index transfers per cycle (throughput 1/cycle with idx_ready held high).
REQ-020 DONE: SHALL assert done=1 for exactly one cycle, idx_valid=0, then return to IDLE.
REQ-021 idx_valid SHALL be 0 in IDLE and DONE; idx_out SHALL be 0 whenever idx_valid=0.
REQ-022 start SHALL be ignored outside IDLE; mask_in changes after the load cycle SHALL have no effect.
REQ-023 abort=1 in SCAN or DONE SHALL go to IDLE next cycle, clear remaining mask, suppress done, hold count; abort has priority over transfer and start; abort in IDLE has no effect.
REQ-024 Zero mask: job SHALL complete as IDLE->DONE->IDLE with count=0 and no idx_valid.
REQ-025 Full mask (all Width bits): SHALL emit 0..Width-1 ascending, count reaching Width (requires IdxW+1 bits).

Reset
REQ-026 rst=1 SHALL, on the next edge, force IDLE, remaining mask 0, count 0; idx_valid, idx_out, busy, done all 0; rst has priority over abort, start and transfer, including mid-SCAN.

Structure
REQ-027 Shared package SHALL hold the FSM state enum type and the default Width/IdxW constants.
REQ-028 A sub-module lsb_encoder (Width-bit multi-hot in -> IdxW index out + any-set flag, purely combinational) SHALL compute lowest set bit; the FSM/datapath stays in reg_mask_encoder.

Verification
REQ-029 Reset mid-SCAN: mask 0x0000_00F0, after first transfer assert rst -> next cycle idx_valid=0, busy=0, count=0, no done.
REQ-030 Sparse mask 0x8000_0011, idx_ready held 1 -> idx_out 0,4,31 on three consecutive cycles, then done pulse, count=3.
REQ-031 Backpressure: mask 0x0000_000A, idx_ready low 3 cycles -> idx_out holds 1, then 1 and 3 transfer on ready, count=2.
REQ-032 Zero mask start -> busy 1 cycle, done pulse 1 cycle later than start, count=0, idx_valid never 1.
REQ-033 Full mask 0xFFFF_FFFF, idx_ready=1 -> 32 indices 0..31 ascending, count=32, done once; start pulsed during SCAN ignored.
REQ-034 Abort: mask 0x0000_0707, abort after 2 transfers -> IDLE next cycle, count=2, no done, idx_valid=0.
